// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, datapath widths, ROB entry layout and commit states.
package cpu_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [6:0] CalcOp    = 7'b0110011;
    localparam logic [6:0] CalcImmOp = 7'b0010011;
    localparam logic [6:0] LoadOp    = 7'b0000011;
    localparam logic [6:0] StoreOp   = 7'b0100011;
    localparam logic [6:0] BneOp     = 7'b1100011;
    localparam logic [6:0] LUIOp     = 7'b0110111;
    localparam logic [6:0] AUIPCOp   = 7'b0010111;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic              writesReg;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2
    } commit_state_t;

endpackage

// File: rtl/reorder_buffer_commit_if.sv
// Decode, CDB and regfile write-port signals of the reorder buffer.
interface reorder_buffer_commit_if import cpu_pkg::*; #(
    parameter int TAG_W = 3
);
    logic              flush;
    logic              allocValid;
    logic [REG_W-1:0]  allocDest;
    logic              allocWritesReg;
    logic              allocReady;
    logic [TAG_W-1:0]  allocTag;
    logic              cdbValid;
    logic [TAG_W-1:0]  cdbTag;
    logic [DATA_W-1:0] cdbData;
    logic              ROBwriteEnable;
    logic [REG_W-1:0]  ROBwriteIndex;
    logic [DATA_W-1:0] ROBwriteData;
    logic [TAG_W:0]    robCount;
    logic              robEmpty;

    modport master (
        output flush, allocValid, allocDest, allocWritesReg, cdbValid, cdbTag, cdbData,
        input  allocReady, allocTag, ROBwriteEnable, ROBwriteIndex, ROBwriteData, robCount, robEmpty
    );

    modport slave (
        input  flush, allocValid, allocDest, allocWritesReg, cdbValid, cdbTag, cdbData,
        output allocReady, allocTag, ROBwriteEnable, ROBwriteIndex, ROBwriteData, robCount, robEmpty
    );
endinterface

// File: rtl/rob_commit_fsm.sv
// Retires the ROB head in order and shapes each register write into a clean one-cycle strobe.
module rob_commit_fsm import cpu_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  rob_entry_t        head_entry,
    output logic              pop,
    output logic              write_enable,
    output logic [REG_W-1:0]  write_index,
    output logic [DATA_W-1:0] write_data
);
    commit_state_t state;
    logic          candidate;
    logic          needs_write;

    assign candidate   = head_entry.valid && head_entry.ready;
    assign needs_write = head_entry.writesReg && (head_entry.dest != '0);
    // Retires are only taken from IDLE, so a write's strobe sequence can never be cut short.
    assign pop         = (state == IDLE) && candidate && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            write_enable <= 1'b0;
            write_index  <= '0;
            write_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop && needs_write) begin
                        write_index <= head_entry.dest;
                        write_data  <= head_entry.value;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    write_enable <= 1'b1;
                    state        <= PULSE;
                end
                PULSE: begin
                    write_enable <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    write_enable <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/reorder_buffer_commit.sv
// In-order reorder buffer: allocates in program order, collects CDB results, commits via rob_commit_fsm.
module reorder_buffer_commit import cpu_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    reorder_buffer_commit_if.slave  rob_bus
);
    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   COUNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] PTR_ONE    = TAG_W'(1);

    rob_entry_t       rob [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;
    logic             pop;
    logic             alloc_fire;
    logic             cdb_fire;

    assign rob_bus.allocReady = (count < FULL_COUNT);
    assign rob_bus.allocTag   = tail;
    assign rob_bus.robCount   = count;
    assign rob_bus.robEmpty   = (count == '0);

    assign alloc_fire = rob_bus.allocValid && rob_bus.allocReady && !rob_bus.flush;
    // The targeted entry must already be live; a result for a just-allocated tail slot is dropped.
    assign cdb_fire   = rob_bus.cdbValid && !rob_bus.flush
                        && rob[rob_bus.cdbTag].valid && !rob[rob_bus.cdbTag].ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rob_bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob[i].valid <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                rob[tail].valid     <= 1'b1;
                rob[tail].ready     <= 1'b0;
                rob[tail].writesReg <= rob_bus.allocWritesReg;
                rob[tail].dest      <= rob_bus.allocDest;
                tail                <= tail + PTR_ONE;
            end
            if (cdb_fire) begin
                rob[rob_bus.cdbTag].value <= rob_bus.cdbData;
                rob[rob_bus.cdbTag].ready <= 1'b1;
            end
            if (pop) begin
                rob[head].valid <= 1'b0;
                head            <= head + PTR_ONE;
            end
            case ({alloc_fire, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    rob_commit_fsm u_commit (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (rob_bus.flush),
        .head_entry   (rob[head]),
        .pop          (pop),
        .write_enable (rob_bus.ROBwriteEnable),
        .write_index  (rob_bus.ROBwriteIndex),
        .write_data   (rob_bus.ROBwriteData)
    );
endmodule
